mpsoc_msi_master_port: RTL and testbench

- Master-side endpoint of the MSI crossbar: one instance per AHB master, placed between that master and the SLAVES arbitrating slave ports.
- Decodes HADDR into a one-hot slave-port request and holds the master while the addressed slave port is granted to someone else.
- Replays the buffered address phase once granted, routes the data phase back by slave index, and reports per-port switch permission (can_switch).
- Unmapped addresses are answered by an internal default slave with a two-cycle AHB ERROR.

---
 rtl/mpsoc_msi_master_port_if.sv | 60 ++++++
 rtl/mpsoc_msi_master_port.sv | 175 +++++++++++++++++
 tb/tb_mpsoc_msi_master_port.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_msi_master_port_if.sv
// Bus bundle between one AHB master, its MSI master port and the crossbar slave ports.
// The slave modport is the master port's own view; the master modport is the surrounding fabric.
interface mpsoc_msi_master_port_if #(
    parameter int PLEN   = 64,
    parameter int XLEN   = 64,
    parameter int SLAVES = 5
);
    logic                        mstHSEL;
    logic [PLEN-1:0]             mstHADDR;
    logic [XLEN-1:0]             mstHWDATA;
    logic                        mstHWRITE;
    logic [2:0]                  mstHSIZE;
    logic [2:0]                  mstHBURST;
    logic [3:0]                  mstHPROT;
    logic [1:0]                  mstHTRANS;
    logic                        mstHMASTLOCK;
    logic                        mstHREADY;
    logic [XLEN-1:0]             mstHRDATA;
    logic                        mstHREADYOUT;
    logic                        mstHRESP;

    logic [SLAVES-1:0]           slvHSEL;
    logic [PLEN-1:0]             slvHADDR;
    logic [XLEN-1:0]             slvHWDATA;
    logic                        slvHWRITE;
    logic [2:0]                  slvHSIZE;
    logic [2:0]                  slvHBURST;
    logic [3:0]                  slvHPROT;
    logic [1:0]                  slvHTRANS;
    logic                        slvHMASTLOCK;
    logic                        slvHREADY;
    logic [SLAVES-1:0][XLEN-1:0] slvHRDATA;
    logic [SLAVES-1:0]           slvHREADYOUT;
    logic [SLAVES-1:0]           slvHRESP;

    logic [SLAVES-1:0]           granted;
    logic [SLAVES-1:0]           can_switch;

    modport slave (
        input  mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE, mstHBURST,
               mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY,
        output mstHRDATA, mstHREADYOUT, mstHRESP,
        output slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST,
               slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY,
        input  slvHRDATA, slvHREADYOUT, slvHRESP,
        input  granted,
        output can_switch
    );

    modport master (
        output mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE, mstHBURST,
               mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY,
        input  mstHRDATA, mstHREADYOUT, mstHRESP,
        input  slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST,
               slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY,
        output slvHRDATA, slvHREADYOUT, slvHRESP,
        output granted,
        input  can_switch
    );
endinterface

// File: rtl/mpsoc_msi_master_port.sv
// MSI crossbar master port: decodes one AHB master onto one-hot slave-port requests,
// stalls and replays the address phase until granted, and errors unmapped addresses.
module mpsoc_msi_master_port #(
    parameter int PLEN   = 64,
    parameter int XLEN   = 64,
    parameter int SLAVES = 5
) (
    input  logic                        HRESETn,
    input  logic                        HCLK,
    input  logic [SLAVES-1:0][PLEN-1:0] slvHADDRmask,
    input  logic [SLAVES-1:0][PLEN-1:0] slvHADDRbase,
    mpsoc_msi_master_port_if.slave      bus
);
    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    typedef enum logic [1:0] {NORMAL, WAIT_GRANT, ERR1, ERR2} state_t;
    state_t state, state_nxt;

    logic [PLEN-1:0] h_addr;
    logic            h_write;
    logic [2:0]      h_size;
    logic [2:0]      h_burst;
    logic [3:0]      h_prot;
    logic            h_lock;

    logic            dsel_vld, dsel_vld_nxt;
    logic [SW-1:0]   dsel, dsel_nxt;
    logic [PLEN-1:0] dec_addr;
    logic            hit;
    logic [SW-1:0]   idx;
    logic            waiting, replay, active, capture, ready_out;

    assign waiting  = (state == WAIT_GRANT);
    assign dec_addr = waiting ? h_addr : bus.mstHADDR;
    assign active   = bus.mstHSEL & bus.mstHREADY & bus.mstHTRANS[1];
    assign replay   = waiting & bus.granted[idx];

    // Scan downwards so the lowest matching region is the one left standing.
    always_comb begin
        logic [SW-1:0] j;
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = SLAVES; i > 0; i--) begin
            j = SW'(i - 1);
            if ((dec_addr & slvHADDRmask[j]) == (slvHADDRbase[j] & slvHADDRmask[j])) begin
                hit = 1'b1;
                idx = j;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= NORMAL;
            dsel_vld <= 1'b0;
            dsel     <= '0;
            h_addr   <= '0;
            h_write  <= 1'b0;
            h_size   <= '0;
            h_burst  <= '0;
            h_prot   <= '0;
            h_lock   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dsel_vld <= dsel_vld_nxt;
            dsel     <= dsel_nxt;
            if (capture) begin
                h_addr  <= bus.mstHADDR;
                h_write <= bus.mstHWRITE;
                h_size  <= bus.mstHSIZE;
                h_burst <= bus.mstHBURST;
                h_prot  <= bus.mstHPROT;
                h_lock  <= bus.mstHMASTLOCK;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        dsel_vld_nxt = dsel_vld;
        dsel_nxt     = dsel;
        capture      = 1'b0;
        case (state)
            NORMAL, ERR2: begin
                if (ready_out) begin
                    state_nxt    = NORMAL;
                    dsel_vld_nxt = 1'b0;
                    if (active) begin
                        if (!hit) begin
                            state_nxt = ERR1;
                        end else if (bus.granted[idx]) begin
                            dsel_vld_nxt = 1'b1;
                            dsel_nxt     = idx;
                        end else begin
                            capture   = 1'b1;
                            state_nxt = WAIT_GRANT;
                        end
                    end
                end
            end
            WAIT_GRANT: begin
                // Replay data phase is claimed while the master is still stalled.
                if (replay) begin
                    state_nxt    = NORMAL;
                    dsel_vld_nxt = 1'b1;
                    dsel_nxt     = idx;
                end
            end
            ERR1:    state_nxt = ERR2;
            default: state_nxt = NORMAL;
        endcase
    end

    always_comb begin
        ready_out     = 1'b1;
        bus.mstHRESP  = 1'b0;
        bus.mstHRDATA = dsel_vld ? bus.slvHRDATA[dsel] : '0;
        case (state)
            NORMAL: begin
                if (dsel_vld) begin
                    ready_out    = bus.slvHREADYOUT[dsel];
                    bus.mstHRESP = bus.slvHRESP[dsel];
                end
            end
            WAIT_GRANT: ready_out = 1'b0;
            ERR1: begin
                ready_out    = 1'b0;
                bus.mstHRESP = 1'b1;
            end
            default: bus.mstHRESP = 1'b1;
        endcase
    end

    assign bus.mstHREADYOUT = ready_out;

    always_comb begin
        bus.slvHSEL      = '0;
        bus.slvHADDR     = bus.mstHADDR;
        bus.slvHWDATA    = bus.mstHWDATA;
        bus.slvHWRITE    = bus.mstHWRITE;
        bus.slvHSIZE     = bus.mstHSIZE;
        bus.slvHBURST    = bus.mstHBURST;
        bus.slvHPROT     = bus.mstHPROT;
        bus.slvHTRANS    = bus.mstHTRANS;
        bus.slvHMASTLOCK = bus.mstHMASTLOCK;
        bus.slvHREADY    = ready_out;
        bus.can_switch   = '1;
        if (waiting) begin
            bus.slvHSEL[idx] = 1'b1;
            bus.slvHADDR     = h_addr;
            bus.slvHWRITE    = h_write;
            bus.slvHSIZE     = h_size;
            bus.slvHBURST    = h_burst;
            bus.slvHPROT     = h_prot;
            bus.slvHMASTLOCK = h_lock;
            bus.slvHTRANS    = replay ? NONSEQ : IDLE;
            bus.slvHREADY    = 1'b1;
            if (replay || h_lock) bus.can_switch[idx] = 1'b0;
        end else if (bus.mstHSEL && hit) begin
            bus.slvHSEL[idx] = 1'b1;
            if (bus.mstHMASTLOCK || bus.mstHTRANS == SEQ || bus.mstHTRANS == BUSY)
                bus.can_switch[idx] = 1'b0;
        end
        // Pass-through paths must also read as idle while reset is held.
        if (!HRESETn) begin
            bus.slvHSEL    = '0;
            bus.slvHTRANS  = IDLE;
            bus.can_switch = '1;
        end
    end
endmodule

// File: tb/tb_mpsoc_msi_master_port.sv
// Directed bench for mpsoc_msi_master_port: decode, grant stall/replay, burst re-arbitration,
// default-slave ERROR, lock and reset-while-waiting.
module tb_mpsoc_msi_master_port;
    localparam int PLEN   = 64;
    localparam int XLEN   = 64;
    localparam int SLAVES = 5;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;

    logic HCLK;
    logic HRESETn;
    logic [SLAVES-1:0][PLEN-1:0] mask;
    logic [SLAVES-1:0][PLEN-1:0] base;
    int checks   = 0;
    int failures = 0;

    mpsoc_msi_master_port_if #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) bus ();

    mpsoc_msi_master_port #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) dut (
        .HRESETn      (HRESETn),
        .HCLK         (HCLK),
        .slvHADDRmask (mask),
        .slvHADDRbase (base),
        .bus          (bus)
    );

    // Single-master bus: HREADY is this port's own HREADYOUT.
    assign bus.mstHREADY = bus.mstHREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [63:0] rd(input int s);
        return 64'hA5A5_0000_0000_0000 + 64'(s);
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic req(input logic sel, input logic [63:0] addr, input logic [1:0] trans,
                       input logic write, input logic [2:0] burst, input logic lock);
        bus.mstHSEL      = sel;
        bus.mstHADDR     = addr;
        bus.mstHTRANS    = trans;
        bus.mstHWRITE    = write;
        bus.mstHBURST    = burst;
        bus.mstHMASTLOCK = lock;
        bus.mstHSIZE     = 3'b010;
        bus.mstHPROT     = 4'b0011;
    endtask

    task automatic idle();
        req(1'b0, 64'h0, IDLE, 1'b0, SINGLE, 1'b0);
    endtask

    task automatic next();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    initial begin
        for (int s = 0; s < SLAVES; s++) begin
            mask[s] = 64'hFFFF_FFFF_FFFF_F000;
            base[s] = 64'(s) << 12;
            bus.slvHRDATA[s] = rd(s);
        end
        mask[2] = 64'h0000_0000_0000_F000;
        base[4] = 64'h3000;
        bus.slvHREADYOUT = '1;
        bus.slvHRESP     = '0;
        bus.granted      = '0;
        bus.mstHWDATA    = '0;

        // Reset with the master already driving a locked NONSEQ
        HRESETn = 1'b0;
        req(1'b1, 64'h2010, NONSEQ, 1'b0, SINGLE, 1'b1);
        #2;
        check("rst_hsel",  64'(bus.slvHSEL), 64'h0);
        check("rst_trans", 64'(bus.slvHTRANS), 64'h0);
        check("rst_ready", 64'(bus.mstHREADYOUT), 64'h1);
        check("rst_resp",  64'(bus.mstHRESP), 64'h0);
        check("rst_rdata", bus.mstHRDATA, 64'h0);
        check("rst_cs",    64'(bus.can_switch), 64'h1F);
        @(negedge HCLK);
        idle();
        HRESETn = 1'b1;
        next();

        // Granted single read
        bus.granted = 5'b00100;
        req(1'b1, 64'h2010, NONSEQ, 1'b0, SINGLE, 1'b0);
        sample();
        check("t1_hsel",  64'(bus.slvHSEL), 64'h04);
        check("t1_haddr", bus.slvHADDR, 64'h2010);
        check("t1_trans", 64'(bus.slvHTRANS), 64'h2);
        check("t1_ready", 64'(bus.mstHREADYOUT), 64'h1);
        next(); idle(); sample();
        check("t1_rdata", bus.mstHRDATA, rd(2));
        check("t1_ready_dp", 64'(bus.mstHREADYOUT), 64'h1);
        check("t1_resp", 64'(bus.mstHRESP), 64'h0);
        next();

        // Read stalled three cycles waiting for the grant, then replayed
        bus.granted = 5'b00000;
        req(1'b1, 64'h2010, NONSEQ, 1'b0, SINGLE, 1'b0);
        sample();
        check("t2_hsel", 64'(bus.slvHSEL), 64'h04);
        next(); idle();
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t2_stall",      64'(bus.mstHREADYOUT), 64'h0);
            check("t2_hold_hsel",  64'(bus.slvHSEL), 64'h04);
            check("t2_hold_trans", 64'(bus.slvHTRANS), 64'h0);
            check("t2_slv_hready", 64'(bus.slvHREADY), 64'h1);
            next();
        end
        bus.granted = 5'b00100;
        sample();
        check("t2_rep_trans", 64'(bus.slvHTRANS), 64'h2);
        check("t2_rep_addr",  bus.slvHADDR, 64'h2010);
        check("t2_rep_hsel",  64'(bus.slvHSEL), 64'h04);
        check("t2_rep_stall", 64'(bus.mstHREADYOUT), 64'h0);
        check("t2_rep_cs",    64'(bus.can_switch), 64'h1B);
        next(); sample();
        check("t2_rdata", bus.mstHRDATA, rd(2));
        check("t2_done",  64'(bus.mstHREADYOUT), 64'h1);
        next();

        // INCR4 write, grant lost before beat 3
        req(1'b1, 64'h2000, NONSEQ, 1'b1, INCR4, 1'b0);
        sample();
        check("t3_b1_cs", 64'(bus.can_switch), 64'h1F);
        next(); req(1'b1, 64'h2004, SEQ, 1'b1, INCR4, 1'b0); bus.mstHWDATA = 64'h1111;
        sample();
        check("t3_b2_cs",    64'(bus.can_switch), 64'h1B);
        check("t3_b2_wdata", bus.slvHWDATA, 64'h1111);
        next(); bus.granted = 5'b00000;
        req(1'b1, 64'h2008, SEQ, 1'b1, INCR4, 1'b0); bus.mstHWDATA = 64'h2222;
        sample();
        check("t3_b3_cs",   64'(bus.can_switch), 64'h1B);
        check("t3_b3_hsel", 64'(bus.slvHSEL), 64'h04);
        next(); req(1'b1, 64'h200C, SEQ, 1'b1, INCR4, 1'b0); bus.mstHWDATA = 64'h3333;
        sample();
        check("t3_wait_ready", 64'(bus.mstHREADYOUT), 64'h0);
        check("t3_wait_trans", 64'(bus.slvHTRANS), 64'h0);
        check("t3_wait_addr",  bus.slvHADDR, 64'h2008);
        next(); bus.granted = 5'b00100;
        sample();
        check("t3_rep_trans", 64'(bus.slvHTRANS), 64'h2);
        check("t3_rep_addr",  bus.slvHADDR, 64'h2008);
        check("t3_rep_burst", 64'(bus.slvHBURST), 64'h3);
        check("t3_rep_write", 64'(bus.slvHWRITE), 64'h1);
        check("t3_rep_wdata", bus.slvHWDATA, 64'h3333);
        check("t3_rep_cs",    64'(bus.can_switch), 64'h1B);
        next(); sample();
        check("t3_b4_ready", 64'(bus.mstHREADYOUT), 64'h1);
        check("t3_b4_trans", 64'(bus.slvHTRANS), 64'h3);
        check("t3_b4_addr",  bus.slvHADDR, 64'h200C);
        check("t3_b4_cs",    64'(bus.can_switch), 64'h1B);
        next(); idle(); bus.mstHWDATA = 64'h4444;
        sample();
        check("t3_end_cs",    64'(bus.can_switch), 64'h1F);
        check("t3_end_ready", 64'(bus.mstHREADYOUT), 64'h1);
        next();

        // Unmapped NONSEQ -> two-cycle ERROR; new request accepted in ERR2
        req(1'b1, 64'hF000_0000, NONSEQ, 1'b0, SINGLE, 1'b0);
        sample();
        check("t4_hsel",  64'(bus.slvHSEL), 64'h0);
        check("t4_ready", 64'(bus.mstHREADYOUT), 64'h1);
        next(); req(1'b1, 64'hF000_0000, IDLE, 1'b0, SINGLE, 1'b0);
        sample();
        check("t4_err1_ready", 64'(bus.mstHREADYOUT), 64'h0);
        check("t4_err1_resp",  64'(bus.mstHRESP), 64'h1);
        next(); req(1'b1, 64'h2020, NONSEQ, 1'b0, SINGLE, 1'b0);
        sample();
        check("t4_err2_ready", 64'(bus.mstHREADYOUT), 64'h1);
        check("t4_err2_resp",  64'(bus.mstHRESP), 64'h1);
        check("t4_err2_hsel",  64'(bus.slvHSEL), 64'h04);
        next(); req(1'b1, 64'hF000_0000, IDLE, 1'b0, SINGLE, 1'b0);
        sample();
        check("t4_post_rdata", bus.mstHRDATA, rd(2));
        check("t4_post_resp",  64'(bus.mstHRESP), 64'h0);
        check("t4_post_ready", 64'(bus.mstHREADYOUT), 64'h1);
        next(); sample();
        check("t4_idle_ready", 64'(bus.mstHREADYOUT), 64'h1);
        check("t4_idle_resp",  64'(bus.mstHRESP), 64'h0);
        next();

        // Overlapping regions 3 and 4: lowest index wins
        bus.granted = '1;
        req(1'b1, 64'h3000, NONSEQ, 1'b0, SINGLE, 1'b0);
        sample();
        check("t5_overlap_hsel", 64'(bus.slvHSEL), 64'h08);
        next();

        // Locked sequence to region 1
        req(1'b1, 64'h1000, NONSEQ, 1'b0, INCR, 1'b1);
        sample();
        check("t6_lock_ns", 64'(bus.can_switch), 64'h1D);
        next(); req(1'b1, 64'h1004, SEQ, 1'b0, INCR, 1'b1);
        sample();
        check("t6_lock_seq", 64'(bus.can_switch), 64'h1D);
        next(); req(1'b1, 64'h1008, IDLE, 1'b0, INCR, 1'b1);
        sample();
        check("t6_lock_idle", 64'(bus.can_switch), 64'h1D);
        next(); req(1'b1, 64'h1008, IDLE, 1'b0, SINGLE, 1'b0);
        sample();
        check("t6_unlock", 64'(bus.can_switch), 64'h1F);
        next();

        // Reset while waiting for a grant drops the held transfer
        bus.granted = 5'b00000;
        req(1'b1, 64'h2010, NONSEQ, 1'b0, SINGLE, 1'b0);
        next(); req(1'b1, 64'h2040, NONSEQ, 1'b0, SINGLE, 1'b0);
        sample();
        check("t7_wait_ready", 64'(bus.mstHREADYOUT), 64'h0);
        #1 HRESETn = 1'b0;
        #1;
        check("t7_rst_hsel",  64'(bus.slvHSEL), 64'h0);
        check("t7_rst_ready", 64'(bus.mstHREADYOUT), 64'h1);
        check("t7_rst_cs",    64'(bus.can_switch), 64'h1F);
        check("t7_rst_trans", 64'(bus.slvHTRANS), 64'h0);
        next(); idle(); bus.granted = 5'b00100; HRESETn = 1'b1;
        sample();
        check("t7_norep_hsel",  64'(bus.slvHSEL), 64'h0);
        check("t7_norep_trans", 64'(bus.slvHTRANS), 64'h0);
        next(); sample();
        check("t7_post_ready", 64'(bus.mstHREADYOUT), 64'h1);
        check("t7_post_rdata", bus.mstHRDATA, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
